usb_in_ep_buff: RTL and testbench



---
 rtl/usb_in_ep_buff.sv | 185 ++++++++++++++++++
 tb/tb_usb_in_ep_buff.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_in_ep_buff.sv
// IN-endpoint packet buffer: application writes and commits packets, the USB TX engine reads them and replays on retry.
// Optional macro BUFF_IN_PINGPONG_EN selects two banks; when it is undefined there is a single bank.
module usb_in_ep_buff #(
  parameter int ADDR_W = 9,
  parameter int LEN_W  = 10
) (
  input  logic              phy_ulpi_clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] buf_in_addr,
  input  logic [7:0]        buf_in_data,
  input  logic              buf_in_wren,
  output logic              buf_in_ready,
  input  logic              buf_in_commit,
  input  logic [LEN_W-1:0]  buf_in_commit_len,
  output logic              buf_in_commit_ack,
  output logic              tx_pkt_avail,
  output logic [LEN_W-1:0]  tx_pkt_len,
  input  logic              tx_rd_en,
  output logic [7:0]        tx_rd_data,
  output logic              tx_rd_valid,
  input  logic              tx_ack,
  input  logic              tx_retry
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DEPTH);
`ifdef BUFF_IN_PINGPONG_EN
  localparam int MEM_AW = ADDR_W + 1;
`else
  localparam int MEM_AW = ADDR_W;
`endif

  typedef enum logic [1:0] {
    ST_FREE = 2'd0,
    ST_FULL = 2'd1,
    ST_SEND = 2'd2
  } bank_state_t;

  bank_state_t      r_state      [2];
  bank_state_t      w_state_next [2];
  logic [LEN_W-1:0] r_len        [2];
  logic [LEN_W-1:0] w_len_next   [2];
  logic [LEN_W-1:0] r_rd_ptr;
  logic [LEN_W-1:0] w_rd_ptr_next;
  logic             w_wr_bank;
  logic             w_rd_bank;
  logic             w_wr_bank_next;
  logic             w_rd_bank_next;

  logic [7:0]        r_mem [DEPTH * (2 ** (MEM_AW - ADDR_W))];
  logic [MEM_AW-1:0] w_wr_addr;
  logic [MEM_AW-1:0] w_rd_addr;
  logic [7:0]        r_rd_data;

  logic             r_ready;
  logic             r_commit_ack;
  logic             r_avail;
  logic [LEN_W-1:0] r_pkt_len;
  logic             r_rd_valid;

  logic             w_wr_ok;
  logic             w_rd_avail;
  logic             w_wr_go;
  logic             w_commit_go;
  logic             w_ack_go;
  logic             w_retry_go;
  logic             w_rd_go;
  logic [LEN_W-1:0] w_commit_len;

  assign w_wr_ok      = (r_state[w_wr_bank] == ST_FREE);
  assign w_rd_avail   = (r_state[w_rd_bank] != ST_FREE);
  assign w_wr_go      = buf_in_wren & w_wr_ok;
  assign w_commit_go  = buf_in_commit & w_wr_ok;
  assign w_ack_go     = tx_ack & w_rd_avail;
  assign w_retry_go   = tx_retry & w_rd_avail & ~tx_ack;
  // A read in the same cycle as ack/retry is dropped so the rewind is clean.
  assign w_rd_go      = tx_rd_en & w_rd_avail & ~tx_ack & ~tx_retry &
                        (r_rd_ptr < r_len[w_rd_bank]);
  assign w_commit_len = (buf_in_commit_len > MAX_LEN) ? MAX_LEN : buf_in_commit_len;

`ifdef BUFF_IN_PINGPONG_EN
  logic r_wr_bank;
  logic r_rd_bank;

  assign w_wr_bank      = r_wr_bank;
  assign w_rd_bank      = r_rd_bank;
  assign w_wr_bank_next = w_commit_go ? ~r_wr_bank : r_wr_bank;
  assign w_rd_bank_next = w_ack_go ? ~r_rd_bank : r_rd_bank;
  assign w_wr_addr      = {r_wr_bank, buf_in_addr};
  assign w_rd_addr      = {r_rd_bank, r_rd_ptr[ADDR_W-1:0]};

  always_ff @(posedge phy_ulpi_clk) begin
    if (reset) begin
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
    end else begin
      r_wr_bank <= w_wr_bank_next;
      r_rd_bank <= w_rd_bank_next;
    end
  end
`else
  assign w_wr_bank      = 1'b0;
  assign w_rd_bank      = 1'b0;
  assign w_wr_bank_next = 1'b0;
  assign w_rd_bank_next = 1'b0;
  assign w_wr_addr      = buf_in_addr;
  assign w_rd_addr      = r_rd_ptr[ADDR_W-1:0];
`endif

  // Commit and ack never target the same bank, so both may apply in one cycle.
  always_comb begin
    w_state_next  = r_state;
    w_len_next    = r_len;
    w_rd_ptr_next = r_rd_ptr;
    if (w_commit_go) begin
      w_state_next[w_wr_bank] = ST_FULL;
      w_len_next[w_wr_bank]   = w_commit_len;
    end
    if (w_ack_go) begin
      w_state_next[w_rd_bank] = ST_FREE;
      w_rd_ptr_next           = '0;
    end else if (w_retry_go) begin
      w_rd_ptr_next = '0;
      if (r_state[w_rd_bank] == ST_SEND) begin
        w_state_next[w_rd_bank] = ST_FULL;
      end
    end else if (w_rd_go) begin
      w_rd_ptr_next           = r_rd_ptr + LEN_W'(1);
      w_state_next[w_rd_bank] = ST_SEND;
    end
  end

  always_ff @(posedge phy_ulpi_clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        r_state[i] <= ST_FREE;
        r_len[i]   <= '0;
      end
      r_rd_ptr <= '0;
    end else begin
      r_state  <= w_state_next;
      r_len    <= w_len_next;
      r_rd_ptr <= w_rd_ptr_next;
    end
  end

  // Status outputs are registered from next-state so they line up with the bank state.
  always_ff @(posedge phy_ulpi_clk) begin
    if (reset) begin
      r_ready      <= 1'b1;
      r_commit_ack <= 1'b0;
      r_avail      <= 1'b0;
      r_pkt_len    <= '0;
      r_rd_valid   <= 1'b0;
    end else begin
      r_ready      <= (w_state_next[w_wr_bank_next] == ST_FREE);
      r_commit_ack <= w_commit_go;
      r_avail      <= (w_state_next[w_rd_bank_next] != ST_FREE);
      r_pkt_len    <= w_len_next[w_rd_bank_next];
      r_rd_valid   <= w_rd_go;
    end
  end

  always_ff @(posedge phy_ulpi_clk) begin
    if (w_wr_go) begin
      r_mem[w_wr_addr] <= buf_in_data;
    end
  end

  always_ff @(posedge phy_ulpi_clk) begin
    if (reset) begin
      r_rd_data <= '0;
    end else if (w_rd_go) begin
      r_rd_data <= r_mem[w_rd_addr];
    end
  end

  assign buf_in_ready      = r_ready;
  assign buf_in_commit_ack = r_commit_ack;
  assign tx_pkt_avail      = r_avail;
  assign tx_pkt_len        = r_pkt_len;
  assign tx_rd_data        = r_rd_data;
  assign tx_rd_valid       = r_rd_valid;

endmodule

// File: tb/tb_usb_in_ep_buff.sv
// Scoreboard bench for usb_in_ep_buff; expected read bytes are queued from a bank model and popped on tx_rd_valid.
// Works in both the single-bank build and with BUFF_IN_PINGPONG_EN defined.
module tb_usb_in_ep_buff;
  localparam int ADDR_W = 9;
  localparam int LEN_W  = 10;
`ifdef BUFF_IN_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] buf_in_addr = '0;
  logic [7:0]        buf_in_data = '0;
  logic              buf_in_wren = 1'b0;
  logic              buf_in_ready;
  logic              buf_in_commit = 1'b0;
  logic [LEN_W-1:0]  buf_in_commit_len = '0;
  logic              buf_in_commit_ack;
  logic              tx_pkt_avail;
  logic [LEN_W-1:0]  tx_pkt_len;
  logic              tx_rd_en = 1'b0;
  logic [7:0]        tx_rd_data;
  logic              tx_rd_valid;
  logic              tx_ack = 1'b0;
  logic              tx_retry = 1'b0;

  always #5 clk = ~clk;

  usb_in_ep_buff #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .phy_ulpi_clk      (clk),
    .reset             (reset),
    .buf_in_addr       (buf_in_addr),
    .buf_in_data       (buf_in_data),
    .buf_in_wren       (buf_in_wren),
    .buf_in_ready      (buf_in_ready),
    .buf_in_commit     (buf_in_commit),
    .buf_in_commit_len (buf_in_commit_len),
    .buf_in_commit_ack (buf_in_commit_ack),
    .tx_pkt_avail      (tx_pkt_avail),
    .tx_pkt_len        (tx_pkt_len),
    .tx_rd_en          (tx_rd_en),
    .tx_rd_data        (tx_rd_data),
    .tx_rd_valid       (tx_rd_valid),
    .tx_ack            (tx_ack),
    .tx_retry          (tx_retry)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] sb[$];
  logic [7:0] m_data [2][512];
  int         m_len  [2];
  bit         m_full [2];
  int         m_ptr;
  int         m_wr;
  int         m_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (tx_rd_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("rd_valid_unexpected", tx_rd_valid, 1'b0);
      end else begin
        logic [7:0] exp_b;
        exp_b = sb.pop_front();
        check("rd_data", tx_rd_data, exp_b);
        $display("rd byte 0x%02h (expected 0x%02h)", tx_rd_data, exp_b);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      m_full[b] = 1'b0;
      m_len[b]  = 0;
    end
    m_ptr = 0;
    m_wr  = 0;
    m_rd  = 0;
  endtask

  task automatic check_reset_outs(input string pfx);
    check({pfx, "_ready"}, buf_in_ready, 1'b1);
    check({pfx, "_ack"}, buf_in_commit_ack, 1'b0);
    check({pfx, "_avail"}, tx_pkt_avail, 1'b0);
    check({pfx, "_len"}, tx_pkt_len, '0);
    check({pfx, "_data"}, tx_rd_data, '0);
    check({pfx, "_valid"}, tx_rd_valid, 1'b0);
    $display("reset outputs checked (%s)", pfx);
  endtask

  task automatic check_status(input string pfx);
    check({pfx, "_avail"}, tx_pkt_avail, m_full[m_rd]);
    check({pfx, "_ready"}, buf_in_ready, !m_full[m_wr]);
    if (m_full[m_rd]) check({pfx, "_len"}, tx_pkt_len, m_len[m_rd]);
  endtask

  task automatic write_bytes(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      buf_in_wren = 1'b1;
      buf_in_addr = ADDR_W'(i);
      buf_in_data = 8'(base + i);
      if (!m_full[m_wr]) m_data[m_wr][i] = 8'(base + i);
      tick();
    end
    buf_in_wren = 1'b0;
    $display("wrote %0d bytes from 0x%02h", n, base);
  endtask

  task automatic commit(input int len);
    bit exp_ok;
    exp_ok = !m_full[m_wr];
    buf_in_commit     = 1'b1;
    buf_in_commit_len = LEN_W'(len);
    tick();
    buf_in_commit = 1'b0;
    buf_in_wren   = 1'b0;
    if (exp_ok) begin
      m_len[m_wr]  = (len > 512) ? 512 : len;
      m_full[m_wr] = 1'b1;
      m_wr         = (m_wr + 1) % NB;
    end
    check("commit_ack", buf_in_commit_ack, exp_ok);
    check_status("commit");
    tick();
    check("commit_ack_end", buf_in_commit_ack, 1'b0);
    $display("commit len %0d: ack=%0b avail=%0b pkt_len=%0d", len, exp_ok, tx_pkt_avail, tx_pkt_len);
  endtask

  task automatic read_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      tx_rd_en = 1'b1;
      if (m_full[m_rd] && m_ptr < m_len[m_rd]) begin
        sb.push_back(m_data[m_rd][m_ptr]);
        m_ptr++;
      end
      tick();
    end
    tx_rd_en = 1'b0;
  endtask

  task automatic do_retry();
    tx_retry = 1'b1;
    tx_rd_en = 1'b1;
    tick();
    tx_retry = 1'b0;
    tx_rd_en = 1'b0;
    if (m_full[m_rd]) m_ptr = 0;
    check_status("retry");
    $display("retry: avail=%0b", tx_pkt_avail);
  endtask

  task automatic do_ack();
    tx_ack   = 1'b1;
    tx_retry = 1'b1;
    tx_rd_en = 1'b1;
    tick();
    tx_ack   = 1'b0;
    tx_retry = 1'b0;
    tx_rd_en = 1'b0;
    if (m_full[m_rd]) begin
      m_full[m_rd] = 1'b0;
      m_ptr        = 0;
      m_rd         = (m_rd + 1) % NB;
    end
    check_status("ack");
    $display("ack: avail=%0b ready=%0b", tx_pkt_avail, buf_in_ready);
  endtask

  initial begin
    model_reset();
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_reset_outs("idle");

    write_bytes(64, 8'h00);
    commit(64);
    read_bytes(65);

    do_retry();
    read_bytes(10);
    do_retry();
    read_bytes(64);
    do_ack();

    commit(0);
    read_bytes(3);
    do_ack();
    commit(600);
    do_ack();

`ifdef BUFF_IN_PINGPONG_EN
    write_bytes(32, 8'h80);
    commit(32);
    write_bytes(16, 8'hC0);
    commit(16);
    commit(5);
    read_bytes(32);
    do_ack();
    write_bytes(5, 8'h50);
    commit(5);
    read_bytes(16);
    do_ack();
    read_bytes(6);
    do_ack();
`else
    write_bytes(64, 8'h40);
    commit(64);
    write_bytes(8, 8'hAA);
    commit(10);
    read_bytes(64);
    do_ack();
`endif

    write_bytes(64, 8'h10);
    commit(64);
    read_bytes(20);
    reset    = 1'b1;
    tx_rd_en = 1'b1;
    tick();
    check_reset_outs("rst_mid");
    reset    = 1'b0;
    tx_rd_en = 1'b0;
    model_reset();
    tick();
    check("rst_sb_empty", sb.size(), 0);

    write_bytes(3, 8'hE0);
    buf_in_wren = 1'b1;
    buf_in_addr = ADDR_W'(3);
    buf_in_data = 8'hE3;
    m_data[m_wr][3] = 8'hE3;
    commit(4);
    read_bytes(5);
    do_ack();

    repeat (3) tick();
    check("sb_drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
